// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection signal controller:
//   - light_e  : per-lane signal head code (RED / YELLOW / GREEN)
//   - phase_e  : sequencer phase code (ALL_RED / GREEN / YELLOW)
//   - DIR_*    : pair-wise one-hot green request codes, two lanes per direction
//   - heads_t  : packed array of all eight lane heads
//   - helpers  : request legality test and lane-head decode
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10
    } light_e;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10
    } phase_e;

    localparam logic [7:0] DIR_N = 8'h03;
    localparam logic [7:0] DIR_E = 8'h0C;
    localparam logic [7:0] DIR_S = 8'h30;
    localparam logic [7:0] DIR_W = 8'hC0;

    typedef logic [7:0][1:0] heads_t;

    // A request is only meaningful if it names exactly one full direction pair.
    function automatic logic is_legal_dir(input logic [7:0] dir);
        return (dir == DIR_N) || (dir == DIR_E) || (dir == DIR_S) || (dir == DIR_W);
    endfunction

    // Lanes selected in dir show code; every other lane is held red.
    function automatic heads_t decode_heads(input logic [7:0] dir, input light_e code);
        heads_t h;
        for (int i = 0; i < 8; i++) begin
            h[i] = dir[i] ? code : LIGHT_RED;
        end
        return h;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that measures phase length in ticks.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (count returns to RST_VAL)
//   load     in   load load_val this cycle (takes priority over counting)
//   load_val in   TW-bit value loaded on entry to a phase
//   tick     in   timing enable; the count only moves on tick
//   count    out  current remaining ticks
//   expire   out  combinational: this tick ends the phase (tick & count==1)
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned     TW      = 8,
    parameter logic [TW-1:0]   RST_VAL = TW'(1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic [TW-1:0] count,
    output logic          expire
);

    logic [TW-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign count  = count_q;
    assign expire = tick && (count_q == TW'(1));

endmodule

// File: rtl/light_phase_sequencer.sv
// -----------------------------------------------------------------------------
// light_phase_sequencer
// Drives all eight lane heads through GREEN -> YELLOW -> ALL_RED using tick-based
// timing. A new green request is sampled only at the end of each all-red
// clearance; green length grows with the cars waiting in the granted pair.
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick       in   1-cycle timing enable; timers move only on tick
//   req        in   8-bit pair-wise one-hot green request
//   lane       in   car count per lane, lane[0]=N1 .. lane[7]=W2
//   lights     out  per-lane head: 00 red, 01 yellow, 10 green (registered)
//   phase      out  00 ALL_RED, 01 GREEN, 10 YELLOW (registered)
//   active_dir out  request latched for the current green/yellow, 0 in ALL_RED
//   sample_stb out  1-cycle pulse, cycle after req is sampled
//   req_err    out  1-cycle pulse, cycle after an illegal req is sampled
// -----------------------------------------------------------------------------
module light_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned TW            = 8,
    parameter int unsigned MIN_GREEN     = 5,
    parameter int unsigned MAX_GREEN     = 60,
    parameter int unsigned TICKS_PER_CAR = 1,
    parameter int unsigned YELLOW_TIME   = 3,
    parameter int unsigned CLEAR_TIME    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [7:0]      req,
    input  logic [7:0][7:0] lane,
    output logic [7:0][1:0] lights,
    output logic [1:0]      phase,
    output logic [7:0]      active_dir,
    output logic            sample_stb,
    output logic            req_err
);

    // Width for the unsaturated green length: a 9-bit pair sum scaled by
    // TICKS_PER_CAR plus MIN_GREEN, with one spare bit so 255+255 never wraps.
    localparam int unsigned GW = 9 + $clog2(TICKS_PER_CAR + 1) + 1;

    phase_e          phase_q;
    logic [7:0]      active_dir_q;
    heads_t          lights_q;
    logic            sample_stb_q;
    logic            req_err_q;

    logic            req_legal;
    logic [8:0]      pair_sum;
    logic [GW-1:0]   green_raw;
    logic [TW-1:0]   green_len;

    logic            timer_load;
    logic [TW-1:0]   timer_load_val;
    logic [TW-1:0]   timer_count;
    logic            timer_expire;
    logic            unused_timer_count;

    assign req_legal = is_legal_dir(req);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pair_sum = '0;
        case (req)
            DIR_N:   pair_sum = {1'b0, lane[0]} + {1'b0, lane[1]};
            DIR_E:   pair_sum = {1'b0, lane[2]} + {1'b0, lane[3]};
            DIR_S:   pair_sum = {1'b0, lane[4]} + {1'b0, lane[5]};
            DIR_W:   pair_sum = {1'b0, lane[6]} + {1'b0, lane[7]};
            default: pair_sum = '0;
        endcase
    end

    assign green_raw = GW'(MIN_GREEN) + (GW'(pair_sum) * GW'(TICKS_PER_CAR));
    assign green_len = (green_raw > GW'(MAX_GREEN)) ? TW'(MAX_GREEN) : green_raw[TW-1:0];

    // The timer is reloaded on every exit tick with the length of the phase
    // being entered; an illegal sample re-enters ALL_RED for a full clearance.
    always_comb begin
        timer_load_val = TW'(CLEAR_TIME);
        case (phase_q)
            PH_ALL_RED: timer_load_val = req_legal ? green_len : TW'(CLEAR_TIME);
            PH_GREEN:   timer_load_val = TW'(YELLOW_TIME);
            default:    timer_load_val = TW'(CLEAR_TIME);
        endcase
    end

    assign timer_load = timer_expire;

    phase_timer #(
        .TW      (TW),
        .RST_VAL (TW'(CLEAR_TIME))
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (tick),
        .count    (timer_count),
        .expire   (timer_expire)
    );

    // The remaining count is only of interest to observers of the timer.
    assign unused_timer_count = ^timer_count;

    // NOTE: every control register is reset; there is no memory array here,
    // so nothing is left to power up in an unknown state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_ALL_RED;
            active_dir_q <= '0;
            lights_q     <= '0;
            sample_stb_q <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            sample_stb_q <= 1'b0;
            req_err_q    <= 1'b0;
            if (timer_expire) begin
                case (phase_q)
                    PH_ALL_RED: begin
                        sample_stb_q <= 1'b1;
                        if (req_legal) begin
                            phase_q      <= PH_GREEN;
                            active_dir_q <= req;
                            lights_q     <= decode_heads(req, LIGHT_GREEN);
                        end else begin
                            req_err_q    <= 1'b1;
                        end
                    end
                    PH_GREEN: begin
                        phase_q  <= PH_YELLOW;
                        lights_q <= decode_heads(active_dir_q, LIGHT_YELLOW);
                    end
                    default: begin
                        // YELLOW, and recovery from any unused encoding.
                        phase_q      <= PH_ALL_RED;
                        active_dir_q <= '0;
                        lights_q     <= '0;
                    end
                endcase
            end
        end
    end

    assign lights     = lights_q;
    assign phase      = phase_q;
    assign active_dir = active_dir_q;
    assign sample_stb = sample_stb_q;
    assign req_err    = req_err_q;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_light_phase_sequencer
// Directed scenarios followed by a randomized run. Expected outputs come from a
// tick-counting reference model of the phase schedule kept in this file.
// -----------------------------------------------------------------------------
module tb_light_phase_sequencer;

    localparam int MIN_G = 5;
    localparam int MAX_G = 60;
    localparam int TPC   = 1;
    localparam int YEL   = 3;
    localparam int CLR   = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            tick  = 1'b0;
    logic [7:0]      req   = '0;
    logic [7:0][7:0] lane  = '0;
    logic [7:0][1:0] lights;
    logic [1:0]      phase;
    logic [7:0]      active_dir;
    logic            sample_stb;
    logic            req_err;

    light_phase_sequencer #(
        .TW            (8),
        .MIN_GREEN     (MIN_G),
        .MAX_GREEN     (MAX_G),
        .TICKS_PER_CAR (TPC),
        .YELLOW_TIME   (YEL),
        .CLEAR_TIME    (CLR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .req        (req),
        .lane       (lane),
        .lights     (lights),
        .phase      (phase),
        .active_dir (active_dir),
        .sample_stb (sample_stb),
        .req_err    (req_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase code (0 all-red, 1 green, 2 yellow), ticks left.
    int         m_phase;
    int         m_left;
    logic [7:0] m_dir;
    bit         m_stb;
    bit         m_err;
    int         prev_phase;
    int         green_cycles;
    int         err_seen;

    logic [7:0] req_pool [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pair_index(input logic [7:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r == (8'h03 << (2 * k))) return k;
        end
        return -1;
    endfunction

    function automatic int green_ticks(input logic [7:0] r, input logic [7:0][7:0] l);
        int k;
        int g;
        k = pair_index(r);
        g = MIN_G + (int'(l[2*k]) + int'(l[2*k+1])) * TPC;
        return (g > MAX_G) ? MAX_G : g;
    endfunction

    function automatic logic [15:0] exp_lights();
        logic [7:0][1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            if (m_dir[i]) v[i] = (m_phase == 1) ? 2'b10 : 2'b01;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_phase    = 0;
        m_left     = CLR;
        m_dir      = '0;
        m_stb      = 1'b0;
        m_err      = 1'b0;
        prev_phase = 0;
    endtask

    task automatic model_step();
        m_stb = 1'b0;
        m_err = 1'b0;
        if (tick) begin
            m_left--;
            if (m_left == 0) begin
                if (m_phase == 0) begin
                    m_stb = 1'b1;
                    if (pair_index(req) >= 0) begin
                        m_phase = 1;
                        m_dir   = req;
                        m_left  = green_ticks(req, lane);
                    end else begin
                        m_err  = 1'b1;
                        m_left = CLR;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                    m_left  = YEL;
                end else begin
                    m_phase = 0;
                    m_left  = CLR;
                    m_dir   = '0;
                end
            end
        end
    endtask

    // One clock: drive tick, advance the model, compare just after the edge.
    task automatic cycle(input bit t);
        int nonred;
        tick = t;
        model_step();
        @(posedge clk);
        #1;
        check("lights", 32'(lights), 32'(exp_lights()));
        check("phase", 32'(phase), 32'(m_phase));
        check("active_dir", 32'(active_dir), 32'(m_dir));
        check("sample_stb", 32'(sample_stb), 32'(m_stb));
        check("req_err", 32'(req_err), 32'(m_err));
        nonred = 0;
        for (int k = 0; k < 4; k++) begin
            if (lights[2*k] != 2'b00 || lights[2*k+1] != 2'b00) nonred++;
        end
        check("one_dir_max", 32'(nonred <= 1), 32'd1);
        if (prev_phase == 1 && phase != 2'b01) check("green_to_yellow", 32'(phase), 32'd2);
        if (phase == 2'b01) green_cycles++;
        if (req_err) err_seen++;
        prev_phase = int'(phase);
    endtask

    task automatic run(input int n, input int period);
        for (int c = 1; c <= n; c++) cycle((c % period) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_pool[0] = 8'h03; req_pool[1] = 8'h0C; req_pool[2] = 8'h30; req_pool[3] = 8'hC0;
        req_pool[4] = 8'h00; req_pool[5] = 8'h05; req_pool[6] = 8'hFF; req_pool[7] = 8'h01;

        // Reset state, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_lights", 32'(lights), 32'h0);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_active_dir", 32'(active_dir), 32'h0);
        check("rst_sample_stb", 32'(sample_stb), 32'h0);
        check("rst_req_err", 32'(req_err), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: North grant, 2+1 cars -> 8 green ticks, ticks every 10 clk.
        req = 8'h03; lane[0] = 8'd2; lane[1] = 8'd1;
        green_cycles = 0;
        run(145, 10);
        check("t1_green_cycles", 32'(green_cycles), 32'd80);

        // 2: East grant with 255+255 cars saturates at MAX_G ticks.
        lane = '0; lane[2] = 8'd255; lane[3] = 8'd255; req = 8'h0C;
        green_cycles = 0;
        run(130, 2);
        check("t2_green_saturated", 32'(green_cycles), 32'd120);

        // 3: Illegal request at the sample -> one error pulse, stays all-red.
        req = 8'h05;
        err_seen = 0;
        run(5, 2);
        check("t3_err_pulses", 32'(err_seen), 32'd1);

        // 4: South grant, req toggles every clock during green.
        lane = '0; lane[4] = 8'd3; lane[5] = 8'd4; req = 8'h30;
        for (int c = 1; c <= 20; c++) begin
            if (c > 2) req = (c % 2) ? 8'hC0 : 8'h30;
            cycle((c % 2) == 0);
        end
        check("t4_still_green_s", 32'(active_dir), 32'h30);

        // 5: Asynchronous reset in the middle of green.
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_lights", 32'(lights), 32'h0);
        check("t5_async_phase", 32'(phase), 32'h0);
        check("t5_async_dir", 32'(active_dir), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 6: Reach yellow, then hold tick low for 1000 clocks.
        req = 8'h03; lane = '0;
        run(16, 2);
        for (int c = 0; c < 1000; c++) cycle(1'b0);
        check("t6_hold_phase", 32'(phase), 32'd2);
        check("t6_hold_lights", 32'(lights), 32'h0005);
        run(10, 2);

        // Randomized run: random ticks, requests (legal and illegal) and counts.
        for (int c = 0; c < 400; c++) begin
            req = req_pool[$urandom_range(0, 7)];
            for (int i = 0; i < 8; i++) lane[i] = 8'($urandom);
            cycle($urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
